// File: rtl/phy_rx_deframer.sv
// -----------------------------------------------------------------------------
// phy_rx_deframer
//
// Purpose:
//   Receives a PHY byte stream of data and K (control) symbols, recognises
//   STP/SDP ... END/EDB framed packets plus COM-led ordered sets, and writes
//   packet bytes into a first-word-fall-through byte FIFO.
//
//   Packet bytes are written speculatively. An END commits them, making them
//   visible to the consumer. An EDB, a framing error or an overflow rewinds
//   the speculative write pointer, so a partial packet is never seen.
//
// Ports:
//   CLK        in   single rising-edge clock
//   RESET_L    in   asynchronous active-low reset
//   DATA_IN    in   [7:0] received symbol
//   K_IN       in   1 = control symbol, 0 = data byte
//   VALID_IN   in   DATA_IN/K_IN are sampled only while high
//   DATA_OUT   out  [7:0] head-of-FIFO byte (00 when the FIFO is empty)
//   SOP_OUT    out  head byte starts a packet
//   EOP_OUT    out  head byte ends a packet
//   TYPE_OUT   out  0 = TLP (STP framed), 1 = DLLP (SDP framed)
//   VALID_OUT  out  a committed byte is available
//   READY_IN   in   consumer accepts the head byte
//   ERROR_OUT  out  one-cycle pulse on a framing violation
//   DROP_OUT   out  one-cycle pulse when an EDB-nullified packet is dropped
//   SKP_CNT    out  [7:0] count of SKP ordered sets, saturating at 255
// -----------------------------------------------------------------------------
module phy_rx_deframer #(
  parameter int DEPTH = 16
) (
  input  logic       CLK,
  input  logic       RESET_L,
  input  logic [7:0] DATA_IN,
  input  logic       K_IN,
  input  logic       VALID_IN,
  output logic [7:0] DATA_OUT,
  output logic       SOP_OUT,
  output logic       EOP_OUT,
  output logic       TYPE_OUT,
  output logic       VALID_OUT,
  input  logic       READY_IN,
  output logic       ERROR_OUT,
  output logic       DROP_OUT,
  output logic [7:0] SKP_CNT
);

  localparam int AW = $clog2(DEPTH);
  // Pointers carry one extra bit so that full and empty can be told apart.
  localparam int PW = AW + 1;

  localparam logic [7:0] K_STP = 8'hFB;
  localparam logic [7:0] K_SDP = 8'h5C;
  localparam logic [7:0] K_END = 8'hFD;
  localparam logic [7:0] K_EDB = 8'hFE;
  localparam logic [7:0] K_COM = 8'hBC;
  localparam logic [7:0] K_SKP = 8'h1C;
  localparam logic [7:0] K_IDL = 8'h7C;
  localparam logic [7:0] K_FTS = 8'h3C;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_COM_SEEN = 2'd1,
    ST_RX_PKT   = 2'd2,
    ST_DISCARD  = 2'd3
  } state_t;

  // True when the current symbol is the control symbol 'sym'.
  function automatic logic k_is(input logic k, input logic [7:0] d,
                                input logic [7:0] sym);
    return k && (d == sym);
  endfunction

  // ---------------------------------------------------------------------------
  // State, pointers and storage
  // ---------------------------------------------------------------------------
  state_t          r_state;
  state_t          w_state_nxt;

  logic [PW-1:0]   r_wr_ptr;      // speculative write pointer
  logic [PW-1:0]   r_cmt_ptr;     // commit pointer: end of consumer-visible data
  logic [PW-1:0]   r_rd_ptr;      // read pointer

  logic            r_sop_arm;     // next data byte is the first of its packet
  logic            r_type;        // type of the packet being received
  logic            r_error;
  logic            r_drop;
  logic [7:0]      r_skp_cnt;

  logic [7:0]      r_mem_data [DEPTH];
  logic [DEPTH-1:0] r_mem_sop;
  logic [DEPTH-1:0] r_mem_eop;
  logic [DEPTH-1:0] r_mem_type;

  // ---------------------------------------------------------------------------
  // Derived wires
  // ---------------------------------------------------------------------------
  logic [PW-1:0]   w_fill;
  logic            w_full;
  logic            w_pkt_nonempty;
  logic [PW-1:0]   w_wr_prev;
  logic [AW-1:0]   w_wr_idx;
  logic [AW-1:0]   w_last_idx;
  logic [AW-1:0]   w_rd_idx;
  logic            w_valid;
  logic            w_rd_en;

  // Fill is measured from the speculative pointer so uncommitted bytes
  // also consume space.
  assign w_fill         = r_wr_ptr - r_rd_ptr;
  assign w_full         = (w_fill == PW'(DEPTH));
  assign w_pkt_nonempty = (r_wr_ptr != r_cmt_ptr);
  assign w_wr_prev      = r_wr_ptr - PW'(1);
  assign w_wr_idx       = r_wr_ptr[AW-1:0];
  assign w_last_idx     = w_wr_prev[AW-1:0];
  assign w_rd_idx       = r_rd_ptr[AW-1:0];
  assign w_valid        = (r_cmt_ptr != r_rd_ptr);
  assign w_rd_en        = w_valid && READY_IN;

  // Symbol decode of the current input.
  logic w_is_data;
  logic w_is_stp;
  logic w_is_sdp;
  logic w_is_end;
  logic w_is_edb;
  logic w_is_com;
  logic w_is_skp;
  logic w_is_idl;
  logic w_is_fts;

  assign w_is_data = !K_IN;
  assign w_is_stp  = k_is(K_IN, DATA_IN, K_STP);
  assign w_is_sdp  = k_is(K_IN, DATA_IN, K_SDP);
  assign w_is_end  = k_is(K_IN, DATA_IN, K_END);
  assign w_is_edb  = k_is(K_IN, DATA_IN, K_EDB);
  assign w_is_com  = k_is(K_IN, DATA_IN, K_COM);
  assign w_is_skp  = k_is(K_IN, DATA_IN, K_SKP);
  assign w_is_idl  = k_is(K_IN, DATA_IN, K_IDL);
  assign w_is_fts  = k_is(K_IN, DATA_IN, K_FTS);

  // FSM action strobes.
  logic w_wr_en;
  logic w_commit;
  logic w_rewind;
  logic w_err;
  logic w_drop;
  logic w_skp_inc;
  logic w_pkt_start;

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state and action decode; nothing happens without VALID_IN.
  always_comb begin
    w_state_nxt = r_state;
    w_wr_en     = 1'b0;
    w_commit    = 1'b0;
    w_rewind    = 1'b0;
    w_err       = 1'b0;
    w_drop      = 1'b0;
    w_skp_inc   = 1'b0;
    w_pkt_start = 1'b0;

    if (VALID_IN) begin
      case (r_state)
        ST_IDLE: begin
          if (w_is_com) begin
            w_state_nxt = ST_COM_SEEN;
          end else if (w_is_stp || w_is_sdp) begin
            w_state_nxt = ST_RX_PKT;
            w_pkt_start = 1'b1;
          end else begin
            w_err = 1'b1;
          end
        end

        ST_COM_SEEN: begin
          w_state_nxt = ST_IDLE;
          if (w_is_skp) begin
            w_skp_inc = 1'b1;
          end else if (w_is_idl || w_is_fts) begin
            w_skp_inc = 1'b0;
          end else begin
            w_err = 1'b1;
          end
        end

        ST_RX_PKT: begin
          if (w_is_data) begin
            if (w_full) begin
              // Overflow: drop the whole packet and swallow its remainder.
              w_rewind    = 1'b1;
              w_err       = 1'b1;
              w_state_nxt = ST_DISCARD;
            end else begin
              w_wr_en = 1'b1;
            end
          end else if (w_is_end) begin
            w_state_nxt = ST_IDLE;
            if (w_pkt_nonempty) begin
              w_commit = 1'b1;
            end else begin
              w_err = 1'b1;
            end
          end else if (w_is_edb) begin
            w_rewind    = 1'b1;
            w_drop      = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_rewind    = 1'b1;
            w_err       = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end

        ST_DISCARD: begin
          if (w_is_end || w_is_edb) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_DISCARD;
          end
        end

        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  // ---------------------------------------------------------------------------
  // Pointer registers
  // ---------------------------------------------------------------------------
  // Speculative write pointer: advance on write, fall back to commit on rewind.
  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      r_wr_ptr <= {PW{1'b0}};
    end else if (w_wr_en) begin
      r_wr_ptr <= r_wr_ptr + PW'(1);
    end else if (w_rewind) begin
      r_wr_ptr <= r_cmt_ptr;
    end else begin
      r_wr_ptr <= r_wr_ptr;
    end
  end

  // Commit pointer: catches up with the speculative pointer on a good END.
  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      r_cmt_ptr <= {PW{1'b0}};
    end else if (w_commit) begin
      r_cmt_ptr <= r_wr_ptr;
    end else begin
      r_cmt_ptr <= r_cmt_ptr;
    end
  end

  // Read pointer: advances on each consumer handshake.
  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      r_rd_ptr <= {PW{1'b0}};
    end else if (w_rd_en) begin
      r_rd_ptr <= r_rd_ptr + PW'(1);
    end else begin
      r_rd_ptr <= r_rd_ptr;
    end
  end

  // ---------------------------------------------------------------------------
  // Packet context
  // ---------------------------------------------------------------------------
  // SOP arming and packet type, latched from the STP/SDP that opens a packet.
  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      r_sop_arm <= 1'b0;
      r_type    <= 1'b0;
    end else if (w_pkt_start) begin
      r_sop_arm <= 1'b1;
      r_type    <= w_is_sdp;
    end else if (w_wr_en) begin
      r_sop_arm <= 1'b0;
      r_type    <= r_type;
    end else begin
      r_sop_arm <= r_sop_arm;
      r_type    <= r_type;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO storage (no reset; only entries behind the commit pointer are read)
  // ---------------------------------------------------------------------------
  // Entry write on data bytes; EOP patch on the last entry when committing.
  always_ff @(posedge CLK) begin
    if (w_wr_en) begin
      r_mem_data[w_wr_idx] <= DATA_IN;
      r_mem_sop[w_wr_idx]  <= r_sop_arm;
      r_mem_eop[w_wr_idx]  <= 1'b0;
      r_mem_type[w_wr_idx] <= r_type;
    end else if (w_commit) begin
      r_mem_eop[w_last_idx] <= 1'b1;
    end else begin
      r_mem_eop <= r_mem_eop;
    end
  end

  // ---------------------------------------------------------------------------
  // Status outputs
  // ---------------------------------------------------------------------------
  // Error / drop pulses and the saturating SKP counter.
  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      r_error   <= 1'b0;
      r_drop    <= 1'b0;
      r_skp_cnt <= 8'd0;
    end else begin
      r_error <= w_err;
      r_drop  <= w_drop;
      if (w_skp_inc && (r_skp_cnt != 8'hFF)) begin
        r_skp_cnt <= r_skp_cnt + 8'd1;
      end else begin
        r_skp_cnt <= r_skp_cnt;
      end
    end
  end

  assign ERROR_OUT = r_error;
  assign DROP_OUT  = r_drop;
  assign SKP_CNT   = r_skp_cnt;
  assign VALID_OUT = w_valid;

  // Head entry is shown only when committed, so empty (and reset) reads as 0.
  assign DATA_OUT = w_valid ? r_mem_data[w_rd_idx] : 8'h00;
  assign SOP_OUT  = w_valid && r_mem_sop[w_rd_idx];
  assign EOP_OUT  = w_valid && r_mem_eop[w_rd_idx];
  assign TYPE_OUT = w_valid && r_mem_type[w_rd_idx];

endmodule

// File: tb/tb_phy_rx_deframer.sv
// -----------------------------------------------------------------------------
// tb_phy_rx_deframer
//
// Directed self-checking bench for phy_rx_deframer (DEPTH = 16).
// Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_phy_rx_deframer;

  logic       CLK;
  logic       RESET_L;
  logic [7:0] DATA_IN;
  logic       K_IN;
  logic       VALID_IN;
  logic [7:0] DATA_OUT;
  logic       SOP_OUT;
  logic       EOP_OUT;
  logic       TYPE_OUT;
  logic       VALID_OUT;
  logic       READY_IN;
  logic       ERROR_OUT;
  logic       DROP_OUT;
  logic [7:0] SKP_CNT;

  int vectors;
  int miscompares;
  int err_seen;
  int drop_seen;

  localparam logic [7:0] STP = 8'hFB;
  localparam logic [7:0] SDP = 8'h5C;
  localparam logic [7:0] ENDS = 8'hFD;
  localparam logic [7:0] EDB = 8'hFE;
  localparam logic [7:0] COM = 8'hBC;
  localparam logic [7:0] SKP = 8'h1C;
  localparam logic [7:0] IDL = 8'h7C;

  phy_rx_deframer #(.DEPTH(16)) dut (
    .CLK       (CLK),
    .RESET_L   (RESET_L),
    .DATA_IN   (DATA_IN),
    .K_IN      (K_IN),
    .VALID_IN  (VALID_IN),
    .DATA_OUT  (DATA_OUT),
    .SOP_OUT   (SOP_OUT),
    .EOP_OUT   (EOP_OUT),
    .TYPE_OUT  (TYPE_OUT),
    .VALID_OUT (VALID_OUT),
    .READY_IN  (READY_IN),
    .ERROR_OUT (ERROR_OUT),
    .DROP_OUT  (DROP_OUT),
    .SKP_CNT   (SKP_CNT)
  );

  // {VALID, DATA, SOP, EOP, TYPE}
  wire [11:0] head_w = {VALID_OUT, DATA_OUT, SOP_OUT, EOP_OUT, TYPE_OUT};

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Drive one symbol (called at a falling edge), return at the next falling
  // edge where its effect is visible, tallying any pulses seen there.
  task automatic send(input logic k, input logic [7:0] d);
    K_IN = k;
    DATA_IN = d;
    VALID_IN = 1'b1;
    @(negedge CLK);
    VALID_IN = 1'b0;
    if (ERROR_OUT) err_seen++;
    if (DROP_OUT) drop_seen++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      if (ERROR_OUT) err_seen++;
      if (DROP_OUT) drop_seen++;
    end
  endtask

  // Consume the head byte with a one-cycle READY_IN.
  task automatic pop();
    READY_IN = 1'b1;
    idle(1);
    READY_IN = 1'b0;
  endtask

  task automatic test_reset();
    RESET_L = 1'b0;
    VALID_IN = 1'b0;
    K_IN = 1'b0;
    DATA_IN = 8'h00;
    READY_IN = 1'b0;
    repeat (2) @(negedge CLK);
    vectors++;
    if ({head_w, ERROR_OUT, DROP_OUT, SKP_CNT} !== 22'd0) begin
      miscompares++;
      $display("FAIL reset_hold got %h want 0", {head_w, ERROR_OUT, DROP_OUT, SKP_CNT});
    end
    RESET_L = 1'b1;
    idle(2);
    vectors++;
    if ({head_w, ERROR_OUT, DROP_OUT, SKP_CNT} !== 22'd0) begin
      miscompares++;
      $display("FAIL reset_release got %h want 0", {head_w, ERROR_OUT, DROP_OUT, SKP_CNT});
    end
  endtask

  task automatic test_tlp();
    logic [11:0] exp [3];
    int e0;
    e0 = err_seen;
    exp[0] = {1'b1, 8'h01, 1'b1, 1'b0, 1'b0};
    exp[1] = {1'b1, 8'h02, 1'b0, 1'b0, 1'b0};
    exp[2] = {1'b1, 8'h10, 1'b0, 1'b1, 1'b0};
    send(1'b1, STP);
    send(1'b0, 8'h01);
    send(1'b0, 8'h02);
    vectors++;
    if (VALID_OUT !== 1'b0) begin
      miscompares++;
      $display("FAIL tlp_uncommitted VALID_OUT got %b want 0", VALID_OUT);
    end
    send(1'b0, 8'h10);
    send(1'b1, ENDS);
    idle(1);  // hold with READY_IN low
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (head_w !== exp[i]) begin
        miscompares++;
        $display("FAIL tlp_byte%0d got %h want %h", i, head_w, exp[i]);
      end
      pop();
    end
    vectors++;
    if (VALID_OUT !== 1'b0 || err_seen != e0) begin
      miscompares++;
      $display("FAIL tlp_end valid=%b errs=%0d want valid=0 errs=0", VALID_OUT, err_seen - e0);
    end
  endtask

  task automatic test_edb();
    int d0;
    int e0;
    d0 = drop_seen;
    e0 = err_seen;
    send(1'b1, SDP);
    send(1'b0, 8'h20);
    send(1'b0, 8'h40);
    send(1'b1, EDB);
    idle(1);
    vectors++;
    if (drop_seen - d0 != 1 || err_seen != e0 || VALID_OUT !== 1'b0) begin
      miscompares++;
      $display("FAIL edb_drop drops=%0d errs=%0d valid=%b want 1 0 0",
               drop_seen - d0, err_seen - e0, VALID_OUT);
    end
    send(1'b1, SDP);
    send(1'b0, 8'h55);
    send(1'b1, ENDS);
    vectors++;
    if (head_w !== {1'b1, 8'h55, 1'b1, 1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL edb_dllp got %h want %h", head_w, {1'b1, 8'h55, 1'b1, 1'b1, 1'b1});
    end
    pop();
    vectors++;
    if (VALID_OUT !== 1'b0) begin
      miscompares++;
      $display("FAIL edb_empty VALID_OUT got %b want 0", VALID_OUT);
    end
  endtask

  task automatic test_skp();
    int e0;
    e0 = err_seen;
    for (int i = 0; i < 3; i++) begin
      send(1'b1, COM);
      send(1'b1, SKP);
    end
    send(1'b1, COM);
    send(1'b1, IDL);
    vectors++;
    if (SKP_CNT !== 8'd3 || err_seen != e0) begin
      miscompares++;
      $display("FAIL skp_three got cnt=%0d errs=%0d want 3 0", SKP_CNT, err_seen - e0);
    end
    for (int i = 0; i < 300; i++) begin
      send(1'b1, COM);
      send(1'b1, SKP);
    end
    vectors++;
    if (SKP_CNT !== 8'd255 || err_seen != e0) begin
      miscompares++;
      $display("FAIL skp_saturate got cnt=%0d errs=%0d want 255 0", SKP_CNT, err_seen - e0);
    end
  endtask

  task automatic test_overflow();
    int e0;
    e0 = err_seen;
    READY_IN = 1'b0;
    send(1'b1, STP);
    for (int i = 1; i <= 16; i++) send(1'b0, 8'(i));
    vectors++;
    if (err_seen != e0 || VALID_OUT !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_fill errs=%0d valid=%b want 0 0", err_seen - e0, VALID_OUT);
    end
    send(1'b0, 8'd17);
    vectors++;
    if (ERROR_OUT !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_byte17 ERROR_OUT got %b want 1", ERROR_OUT);
    end
    send(1'b1, ENDS);
    idle(1);
    vectors++;
    if (err_seen - e0 != 1 || VALID_OUT !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_discard errs=%0d valid=%b want 1 0", err_seen - e0, VALID_OUT);
    end
    send(1'b1, STP);
    send(1'b0, 8'hA1);
    send(1'b0, 8'hA2);
    send(1'b1, ENDS);
    vectors++;
    if (head_w !== {1'b1, 8'hA1, 1'b1, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL ovf_next0 got %h want %h", head_w, {1'b1, 8'hA1, 1'b1, 1'b0, 1'b0});
    end
    pop();
    vectors++;
    if (head_w !== {1'b1, 8'hA2, 1'b0, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL ovf_next1 got %h want %h", head_w, {1'b1, 8'hA2, 1'b0, 1'b1, 1'b0});
    end
    pop();
  endtask

  task automatic test_back_to_back();
    logic [11:0] exp;
    int e0;
    e0 = err_seen;
    send(1'b1, STP);
    for (int i = 0; i < 16; i++) send(1'b0, 8'h80 + 8'(i));
    send(1'b1, ENDS);
    vectors++;
    if (head_w !== {1'b1, 8'h80, 1'b1, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL b2b_full_head got %h want %h", head_w, {1'b1, 8'h80, 1'b1, 1'b0, 1'b0});
    end
    // A read frees one slot; the next data byte must fit.
    READY_IN = 1'b1;
    send(1'b1, STP);
    READY_IN = 1'b0;
    send(1'b0, 8'hC3);
    // Commit and read on the same cycle.
    READY_IN = 1'b1;
    send(1'b1, ENDS);
    READY_IN = 1'b0;
    for (int i = 2; i < 16; i++) begin
      exp = {1'b1, 8'h80 + 8'(i), 1'b0, (i == 15), 1'b0};
      vectors++;
      if (head_w !== exp) begin
        miscompares++;
        $display("FAIL b2b_drain%0d got %h want %h", i, head_w, exp);
      end
      pop();
    end
    vectors++;
    if (head_w !== {1'b1, 8'hC3, 1'b1, 1'b1, 1'b0} || err_seen != e0) begin
      miscompares++;
      $display("FAIL b2b_second got %h errs=%0d want %h 0", head_w, err_seen - e0,
               {1'b1, 8'hC3, 1'b1, 1'b1, 1'b0});
    end
    pop();
    vectors++;
    if (VALID_OUT !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_empty VALID_OUT got %b want 0", VALID_OUT);
    end
  endtask

  task automatic test_errors();
    int e0;
    e0 = err_seen;
    send(1'b0, 8'h33);
    send(1'b1, COM);
    send(1'b0, 8'h00);
    send(1'b1, STP);
    send(1'b1, ENDS);
    idle(1);
    vectors++;
    if (err_seen - e0 != 3 || VALID_OUT !== 1'b0) begin
      miscompares++;
      $display("FAIL err_three errs=%0d valid=%b want 3 0", err_seen - e0, VALID_OUT);
    end
    send(1'b1, 8'hAA);
    vectors++;
    if (ERROR_OUT !== 1'b1) begin
      miscompares++;
      $display("FAIL err_illegal_k ERROR_OUT got %b want 1", ERROR_OUT);
    end
    send(1'b1, STP);
    send(1'b0, 8'h11);
    send(1'b1, COM);
    vectors++;
    if (ERROR_OUT !== 1'b1 || VALID_OUT !== 1'b0) begin
      miscompares++;
      $display("FAIL err_com_in_pkt err=%b valid=%b want 1 0", ERROR_OUT, VALID_OUT);
    end
  endtask

  task automatic test_reset_mid();
    send(1'b1, STP);
    send(1'b0, 8'h61);
    send(1'b0, 8'h62);
    send(1'b1, ENDS);
    vectors++;
    if (VALID_OUT !== 1'b1) begin
      miscompares++;
      $display("FAIL rstmid_commit VALID_OUT got %b want 1", VALID_OUT);
    end
    send(1'b1, STP);
    send(1'b0, 8'h71);
    send(1'b0, 8'h72);
    K_IN = 1'b0;
    DATA_IN = 8'h73;
    VALID_IN = 1'b1;
    RESET_L = 1'b0;
    #1;
    vectors++;
    if ({head_w, ERROR_OUT, DROP_OUT, SKP_CNT} !== 22'd0) begin
      miscompares++;
      $display("FAIL rstmid_assert got %h want 0", {head_w, ERROR_OUT, DROP_OUT, SKP_CNT});
    end
    @(negedge CLK);
    RESET_L = 1'b1;
    VALID_IN = 1'b0;
    idle(1);
    vectors++;
    if ({head_w, ERROR_OUT, DROP_OUT, SKP_CNT} !== 22'd0) begin
      miscompares++;
      $display("FAIL rstmid_release got %h want 0", {head_w, ERROR_OUT, DROP_OUT, SKP_CNT});
    end
    send(1'b1, STP);
    send(1'b0, 8'h99);
    send(1'b1, ENDS);
    vectors++;
    if (head_w !== {1'b1, 8'h99, 1'b1, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL rstmid_after got %h want %h", head_w, {1'b1, 8'h99, 1'b1, 1'b1, 1'b0});
    end
    pop();
    vectors++;
    if (VALID_OUT !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_empty VALID_OUT got %b want 0", VALID_OUT);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    err_seen = 0;
    drop_seen = 0;
    test_reset();
    test_tlp();
    test_edb();
    test_skp();
    test_overflow();
    test_back_to_back();
    test_errors();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/phy_rx_deframer.md
PHY_RX_DEFRAMER -- requirements
Module: phy_rx_deframer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning the byte-FIFO entries (power of two, at least 4).
REQ-002 SHALL have port CLK, input, 1 bit: the single clock; all logic is rising-edge.
REQ-003 SHALL have port RESET_L, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port DATA_IN, input, 8 bits: received symbol from the PHY byte stream.
REQ-005 SHALL have port K_IN, input, 1 bit: 1 marks DATA_IN as a control symbol, 0 marks it as data.
REQ-006 SHALL have port VALID_IN, input, 1 bit: DATA_IN/K_IN sampled only when 1.
REQ-007 SHALL have port DATA_OUT, output, 8 bits: head-of-FIFO byte.
REQ-008 SHALL have port SOP_OUT, output, 1 bit: head byte is the first byte of a packet.
REQ-009 SHALL have port EOP_OUT, output, 1 bit: head byte is the last byte of a packet.
REQ-010 SHALL have port TYPE_OUT, output, 1 bit: 0 = TLP (STP-framed), 1 = DLLP (SDP-framed).
REQ-011 SHALL have port VALID_OUT, output, 1 bit: a committed byte is available.
REQ-012 SHALL have port READY_IN, input, 1 bit: consumer accepts the head byte.
REQ-013 SHALL have port ERROR_OUT, output, 1 bit: one-cycle pulse on a framing violation.
REQ-014 SHALL have port DROP_OUT, output, 1 bit: one-cycle pulse when an EDB-nullified packet is discarded.
REQ-015 SHALL have port SKP_CNT, output, 8 bits: count of SKP ordered sets received, saturating at 255.

Function
REQ-016 SHALL decode K symbols STP=FB, SDP=5C, END=FD, EDB=FE, COM=BC, SKP=1C, IDL=7C, FTS=3C (hex); any other K value is illegal.
REQ-017 SHALL do nothing in any state on a cycle with VALID_IN=0.
REQ-018 SHALL implement states IDLE, COM_SEEN, RX_PKT and DISCARD.
REQ-019 IDLE: COM -> COM_SEEN; STP or SDP -> RX_PKT, latching the type and arming SOP for the next data byte; a data byte or any other K -> ERROR_OUT pulse, remain in IDLE.
REQ-020 COM_SEEN: SKP -> SKP_CNT+1 (saturating), then IDLE; IDL or FTS -> IDLE; anything else -> ERROR_OUT pulse, then IDLE.
REQ-021 RX_PKT, data byte: write {byte, SOP, EOP=0, type} at the speculative write pointer and increment it.
REQ-022 RX_PKT, END with at least one byte written: set EOP on the last written entry, set the commit pointer to the speculative pointer, go to IDLE.
REQ-023 RX_PKT, END with zero bytes: ERROR_OUT pulse, go to IDLE.
REQ-024 RX_PKT, EDB: rewind the speculative pointer to the commit pointer, DROP_OUT pulse, go to IDLE.
REQ-025 RX_PKT, any other K (including STP, SDP or COM): rewind the speculative pointer, ERROR_OUT pulse, go to IDLE.
REQ-026 RX_PKT, data byte while the FIFO is full (speculative minus read equals DEPTH): do not write, rewind, ERROR_OUT pulse, go to DISCARD.
REQ-027 DISCARD: ignore all symbols until END or EDB, then go to IDLE with no pulse.
REQ-028 Pointers SHALL be log2(DEPTH)+1 bits wide and wrap modulo 2*DEPTH.
REQ-029 VALID_OUT SHALL equal (commit pointer != read pointer); DATA_OUT, SOP_OUT, EOP_OUT and TYPE_OUT SHALL come from the entry at the read pointer (first-word fall-through).
REQ-030 The read pointer SHALL advance when VALID_OUT and READY_IN are both 1; DATA_OUT SHALL hold stable while VALID_OUT=1 and READY_IN=0.
REQ-031 Latency: a packet committed on the END cycle SHALL assert VALID_OUT on the next cycle; uncommitted bytes are never visible.
REQ-032 A read and a commit on the same cycle SHALL both take effect; the space freed by a read is usable by the write on the following cycle.

Reset
REQ-033 While RESET_L=0, SHALL hold state IDLE, all pointers 0, SKP_CNT=0, VALID_OUT=0, ERROR_OUT=0, DROP_OUT=0, SOP/EOP/TYPE_OUT=0 and DATA_OUT=00.
REQ-034 Reset asserted mid-packet SHALL discard both committed and uncommitted bytes.
REQ-035 FIFO storage SHALL need no reset.

Verification
REQ-036 STP, data 01 02 10, END, READY_IN=1 -> three reads: 01 with SOP=1, 02, and 10 with EOP=1, all TYPE=0; no error pulses.
REQ-037 SDP, data 20 40, EDB -> DROP_OUT pulses once, VALID_OUT stays 0; a following SDP, 55, END -> single byte 55 with SOP=EOP=1 and TYPE=1.
REQ-038 COM SKP sent 3 times, then COM IDL -> SKP_CNT=3, no error; a further 300 SKP sets -> SKP_CNT=255.
REQ-039 DEPTH=16, READY_IN=0, STP plus 17 data bytes then END -> ERROR_OUT pulses on byte 17, VALID_OUT=0; the next valid packet is received intact.
REQ-040 Data byte in IDLE, COM followed by data 00, and STP immediately followed by END -> three separate ERROR_OUT pulses.
REQ-041 RESET_L low for 1 cycle midway through the 3rd byte of a committed-then-new packet -> all outputs at reset values, FIFO empty.
